// File: rtl/segre_pkg.sv
// Shared core types: register-file port structs, default port counts and the
// EX/MEM/RVM write-back bundle that feeds the register file.
package segre_pkg;

    localparam int RF_DATA_W     = 32;
    localparam int RF_NUM_REGS   = 32;
    localparam int RF_ADDR_W     = $clog2(RF_NUM_REGS);
    localparam int RF_NUM_RPORTS = 3;
    localparam int RF_NUM_WPORTS = 3;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
        logic                 we;
    } rf_rport_t;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
        logic                 we;
    } rf_wport_t;

    // Existing write-back bundle; the core adapter maps ex/mem/rvm onto ports 0/1/2.
    typedef struct packed {
        logic                 ex_we;
        logic [RF_ADDR_W-1:0] ex_addr;
        logic [RF_DATA_W-1:0] ex_data;
        logic                 mem_we;
        logic [RF_ADDR_W-1:0] mem_addr;
        logic [RF_DATA_W-1:0] mem_data;
        logic                 rvm_we;
        logic [RF_ADDR_W-1:0] rvm_addr;
        logic [RF_DATA_W-1:0] rvm_data;
    } rf_wdata_t;

    function automatic rf_wport_t rf_wdata_port(input rf_wdata_t wd, input int idx);
        rf_wport_t p;
        case (idx)
            0:       p = '{addr: wd.ex_addr,  data: wd.ex_data,  we: wd.ex_we};
            1:       p = '{addr: wd.mem_addr, data: wd.mem_data, we: wd.mem_we};
            default: p = '{addr: wd.rvm_addr, data: wd.rvm_data, we: wd.rvm_we};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/segre_rf_wsel.sv
// Priority write-select for one register address: the lowest-index enabled
// port that targets addr wins. Used by both storage update and read bypass.
module segre_rf_wsel
    import segre_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int NUM_WPORTS = RF_NUM_WPORTS
) (
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [NUM_WPORTS-1:0]              we,
    input  logic [NUM_WPORTS-1:0][ADDR_W-1:0]  waddr,
    input  logic [NUM_WPORTS-1:0][DATA_W-1:0]  wdata,
    output logic                               hit,
    output logic [DATA_W-1:0]                  data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Walk from the lowest priority upwards so port 0 is applied last.
        for (int p = NUM_WPORTS - 1; p >= 0; p--) begin
            if (we[p] && waddr[p] == addr) begin
                hit  = 1'b1;
                data = wdata[p];
            end
        end
    end

endmodule

// File: rtl/segre_regfile_sb.sv
// Integer register file with N read / M prioritised write ports, x0 = 0,
// per-register pending scoreboard, optional write-to-read bypass and flush.
module segre_regfile_sb
    import segre_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int NUM_RPORTS = RF_NUM_RPORTS,
    parameter int NUM_WPORTS = RF_NUM_WPORTS,
    parameter int BYPASS     = 1,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                               clk_i,
    input  logic                               rsn_i,
    input  logic [NUM_RPORTS-1:0][ADDR_W-1:0]  raddr_i,
    output logic [NUM_RPORTS-1:0][DATA_W-1:0]  rdata_o,
    output logic [NUM_RPORTS-1:0]              rbusy_o,
    input  logic [NUM_WPORTS-1:0]              we_i,
    input  logic [NUM_WPORTS-1:0][ADDR_W-1:0]  waddr_i,
    input  logic [NUM_WPORTS-1:0][DATA_W-1:0]  wdata_i,
    input  logic                               rsv_valid_i,
    input  logic [ADDR_W-1:0]                  rsv_addr_i,
    input  logic                               flush_i,
    output logic [NUM_REGS-1:0]                busy_vec_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0]   regs;
    logic [NUM_REGS-1:0]               pending;
    logic [NUM_REGS-1:0]               wr_hit;
    logic [NUM_REGS-1:0][DATA_W-1:0]   wr_data;
    logic [NUM_RPORTS-1:0]             rd_hit;
    logic [NUM_RPORTS-1:0][DATA_W-1:0] rd_data;

    assign wr_hit[0]  = 1'b0;
    assign wr_data[0] = '0;

    for (genvar a = 1; a < NUM_REGS; a++) begin : g_wsel
        segre_rf_wsel #(
            .DATA_W     (DATA_W),
            .ADDR_W     (ADDR_W),
            .NUM_WPORTS (NUM_WPORTS)
        ) u_wsel (
            .addr  (ADDR_W'(a)),
            .we    (we_i),
            .waddr (waddr_i),
            .wdata (wdata_i),
            .hit   (wr_hit[a]),
            .data  (wr_data[a])
        );
    end

    for (genvar r = 0; r < NUM_RPORTS; r++) begin : g_byp
        segre_rf_wsel #(
            .DATA_W     (DATA_W),
            .ADDR_W     (ADDR_W),
            .NUM_WPORTS (NUM_WPORTS)
        ) u_byp (
            .addr  (raddr_i[r]),
            .we    (we_i),
            .waddr (waddr_i),
            .wdata (wdata_i),
            .hit   (rd_hit[r]),
            .data  (rd_data[r])
        );
    end

    // regs[0] is only ever reset, so x0 reads zero without a read-side mux.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_hit[i]) regs[i] <= wr_data[i];
            end
        end
    end

    // A same-cycle reservation beats write-back: the younger producer is still in flight.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (flush_i)
                    pending[i] <= 1'b0;
                else if (rsv_valid_i && rsv_addr_i == ADDR_W'(i))
                    pending[i] <= 1'b1;
                else if (wr_hit[i])
                    pending[i] <= 1'b0;
            end
        end
    end

    // Bypass is held off during reset so outputs settle to zero regardless of inputs.
    always_comb begin
        for (int r = 0; r < NUM_RPORTS; r++) begin
            rdata_o[r] = regs[raddr_i[r]];
            rbusy_o[r] = pending[raddr_i[r]];
            if (BYPASS != 0 && rsn_i && rd_hit[r] && raddr_i[r] != '0)
                rdata_o[r] = rd_data[r];
        end
    end

    assign busy_vec_o = pending;

endmodule

// File: tb/tb_segre_regfile_sb.sv
// Directed bench: one bypassing and one non-bypassing register file share stimulus.
module tb_segre_regfile_sb;

    logic             clk;
    logic             rsn;
    logic [2:0][4:0]  raddr;
    logic [2:0][31:0] rdata_b, rdata_n;
    logic [2:0]       rbusy_b, rbusy_n;
    logic [2:0]       we;
    logic [2:0][4:0]  waddr;
    logic [2:0][31:0] wdata;
    logic             rsv_valid;
    logic [4:0]       rsv_addr;
    logic             flush;
    logic [31:0]      busy_b, busy_n;

    int checks = 0;
    int errors = 0;

    segre_regfile_sb #(.BYPASS(1)) dut_byp (
        .clk_i(clk), .rsn_i(rsn), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_b)
    );

    segre_regfile_sb #(.BYPASS(0)) dut_nob (
        .clk_i(clk), .rsn_i(rsn), .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    // Advance past the next rising edge, drop stimulus, let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic test_reset();
        rsn = 1'b0; raddr = '0; idle();
        #3;
        checks++;
        if (rdata_b !== '0 || rbusy_b !== '0 || busy_b !== '0) begin
            errors++;
            $display("FAIL reset_init: rdata=%h rbusy=%b busy=%h, expected all 0", rdata_b, rbusy_b, busy_b);
        end
        #10 rsn = 1'b1;
        @(negedge clk);
        we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
        rsv_valid = 1'b1; rsv_addr = 5'd8;
        step();
        raddr[0] = 5'd5;
        #1;
        checks++;
        if (rdata_n[0] !== 32'hDEADBEEF || busy_b !== 32'h0000_0100) begin
            errors++;
            $display("FAIL reset_pre: x5=%h busy=%h, expected deadbeef/00000100", rdata_n[0], busy_b);
        end
        #1 rsn = 1'b0;
        #1;
        checks++;
        if (rdata_b[0] !== '0 || rdata_n[0] !== '0 || busy_b !== '0 || busy_n !== '0) begin
            errors++;
            $display("FAIL reset_mid: x5=%h/%h busy=%h/%h, expected 0", rdata_b[0], rdata_n[0], busy_b, busy_n);
        end
        @(negedge clk);
        rsn = 1'b1;
        raddr = '0;
    endtask

    task automatic test_priority();
        @(negedge clk);
        we = 3'b111;
        waddr[0] = 5'd7; waddr[1] = 5'd7; waddr[2] = 5'd7;
        wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33;
        raddr[0] = 5'd7;
        #1;
        checks++;
        if (rdata_b[0] !== 32'h11) begin
            errors++;
            $display("FAIL prio_bypass: got %h, expected 00000011", rdata_b[0]);
        end
        checks++;
        if (rdata_n[0] !== 32'h0) begin
            errors++;
            $display("FAIL prio_nobypass_same: got %h, expected 00000000", rdata_n[0]);
        end
        step();
        checks++;
        if (rdata_b[0] !== 32'h11 || rdata_n[0] !== 32'h11 || busy_b !== '0) begin
            errors++;
            $display("FAIL prio_stored: got %h/%h busy=%h, expected 00000011 busy 0", rdata_b[0], rdata_n[0], busy_b);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'hFFFFFFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        raddr[1] = 5'd0;
        #1;
        checks++;
        if (rdata_b[1] !== '0) begin
            errors++;
            $display("FAIL x0_bypass: got %h, expected 00000000", rdata_b[1]);
        end
        step();
        checks++;
        if (rdata_b[1] !== '0 || rdata_n[1] !== '0 || rbusy_b[1] !== 1'b0 || busy_b !== '0) begin
            errors++;
            $display("FAIL x0_after: rd=%h/%h rbusy=%b busy=%h, expected 0", rdata_b[1], rdata_n[1], rbusy_b[1], busy_b);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        raddr[1] = 5'd9;
        #1;
        checks++;
        if (rbusy_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL sb_nobusybypass: got %b, expected 0", rbusy_b[1]);
        end
        step();
        checks++;
        if (rbusy_b[1] !== 1'b1 || busy_b !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_reserved: rbusy=%b busy=%h, expected 1/00000200", rbusy_b[1], busy_b);
        end
        @(negedge clk);
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        #1;
        step();
        checks++;
        if (busy_b !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_rereserve: busy=%h, expected 00000200", busy_b);
        end
        @(negedge clk);
        we[2] = 1'b1; waddr[2] = 5'd9; wdata[2] = 32'h99;
        #1;
        checks++;
        if (rbusy_b[1] !== 1'b1 || rdata_b[1] !== 32'h99) begin
            errors++;
            $display("FAIL sb_wb_same: rbusy=%b rd=%h, expected 1/00000099", rbusy_b[1], rdata_b[1]);
        end
        step();
        checks++;
        if (rbusy_b[1] !== 1'b0 || rdata_n[1] !== 32'h99 || busy_b !== '0) begin
            errors++;
            $display("FAIL sb_cleared: rbusy=%b rd=%h busy=%h, expected 0/00000099/0", rbusy_b[1], rdata_n[1], busy_b);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        we[1] = 1'b1; waddr[1] = 5'd4; wdata[1] = 32'h44;
        raddr[2] = 5'd4;
        step();
        checks++;
        if (busy_b !== 32'h0000_0010 || rbusy_n[2] !== 1'b1 || rdata_n[2] !== 32'h44) begin
            errors++;
            $display("FAIL coll_rsv_wins: busy=%h rbusy=%b rd=%h, expected 00000010/1/00000044", busy_b, rbusy_n[2], rdata_n[2]);
        end
        @(negedge clk);
        flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd6;
        step();
        checks++;
        if (busy_b !== '0 || busy_n !== '0) begin
            errors++;
            $display("FAIL coll_flush: busy=%h/%h, expected 0", busy_b, busy_n);
        end
    endtask

    task automatic test_bypass0();
        @(negedge clk);
        we[1] = 1'b1; waddr[1] = 5'd3; wdata[1] = 32'hA5;
        raddr[0] = 5'd3;
        #1;
        checks++;
        if (rdata_n[0] !== 32'h0 || rdata_b[0] !== 32'hA5) begin
            errors++;
            $display("FAIL byp0_same: nob=%h byp=%h, expected 00000000/000000a5", rdata_n[0], rdata_b[0]);
        end
        step();
        checks++;
        if (rdata_n[0] !== 32'hA5) begin
            errors++;
            $display("FAIL byp0_next: got %h, expected 000000a5", rdata_n[0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        we = 3'b111;
        waddr[0] = 5'd1;  wdata[0] = 32'h0101;
        waddr[1] = 5'd2;  wdata[1] = 32'h0202;
        waddr[2] = 5'd31; wdata[2] = 32'h1F1F;
        rsv_valid = 1'b1; rsv_addr = 5'd31;
        step();
        raddr[0] = 5'd1; raddr[1] = 5'd2; raddr[2] = 5'd31;
        #1;
        checks++;
        if (rdata_n[0] !== 32'h0101 || rdata_n[1] !== 32'h0202 || rdata_n[2] !== 32'h1F1F) begin
            errors++;
            $display("FAIL b2b_data: got %h %h %h, expected 00000101 00000202 00001f1f", rdata_n[0], rdata_n[1], rdata_n[2]);
        end
        checks++;
        if (rbusy_b !== 3'b100 || busy_b !== 32'h8000_0000) begin
            errors++;
            $display("FAIL b2b_busy: rbusy=%b busy=%h, expected 100/80000000", rbusy_b, busy_b);
        end
        @(negedge clk);
        we[0] = 1'b1; waddr[0] = 5'd31; wdata[0] = 32'hBEEF;
        we[2] = 1'b1; waddr[2] = 5'd2;  wdata[2] = 32'hCAFE;
        #1;
        checks++;
        if (rdata_b[1] !== 32'hCAFE || rdata_b[2] !== 32'hBEEF || rdata_b[0] !== 32'h0101) begin
            errors++;
            $display("FAIL b2b_bypass: got %h %h %h, expected 00000101 0000cafe 0000beef", rdata_b[0], rdata_b[1], rdata_b[2]);
        end
        step();
        checks++;
        if (rdata_n[1] !== 32'hCAFE || rdata_n[2] !== 32'hBEEF || busy_b !== '0) begin
            errors++;
            $display("FAIL b2b_second: got %h %h busy=%h, expected 0000cafe 0000beef 0", rdata_n[1], rdata_n[2], busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_x0();
        test_scoreboard();
        test_collision();
        test_bypass0();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/segre_regfile_sb.md
Name: segre_regfile_sb

Overview:
Parametrised successor to the core's integer register file. It provides N read ports and M prioritised write-back ports, with x0 hardwired to zero. It adds a per-register scoreboard (pending bits) that decode reserves and write-back clears, an optional write-to-read bypass, and a flush that drops all reservations. It sits between decode (reads and reservations) and the EX/MEM/RVM write-back paths.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, architectural registers (power of 2); ADDR_W = $clog2(NUM_REGS)
NUM_RPORTS, 3, read ports (rs1, rs2, store-data)
NUM_WPORTS, 3, write-back ports; index 0 has the highest priority
BYPASS, 1, 1 = a same-cycle write is forwarded to reads; 0 = reads see the registered value only

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, asynchronous, active-low
raddr_i  in  NUM_RPORTS x ADDR_W  read addresses
rdata_o  out  NUM_RPORTS x DATA_W  read data
rbusy_o  out  NUM_RPORTS  pending bit of each read address
we_i  in  NUM_WPORTS  write enables
waddr_i  in  NUM_WPORTS x ADDR_W  write addresses
wdata_i  in  NUM_WPORTS x DATA_W  write data
rsv_valid_i  in  1  reserve destination (decode issue)
rsv_addr_i  in  ADDR_W  destination to reserve
flush_i  in  1  clear all pending bits (pipeline flush)
busy_vec_o  out  NUM_REGS  full scoreboard, for debug and stall logic

Behaviour:
- Reset (rsn_i low, asynchronous): all registers = 0, all pending bits = 0. The outputs settle combinationally: rdata_o = 0, rbusy_o = 0, busy_vec_o = 0. Reset mid-operation discards in-flight writes and reservations.
- Register 0: it is never written and never pending. Reads always return 0 and rbusy = 0. Writes and reservations to address 0 are ignored.
- Write: on posedge clk_i, reg[a] <= wdata of the lowest-index port p with we_i[p] && waddr_i[p] == a, a != 0. Different addresses written in the same cycle all commit.
- Read: combinational, zero latency. With BYPASS=1, if any enabled write port targets raddr (!= 0) in this cycle, rdata returns that port's data, using the same priority as the write. With BYPASS=0, rdata returns the stored value, and the new value is visible the next cycle.
- Scoreboard, per register a != 0, next pending[a] is decided in this order:
  - flush_i = 1 -> 0. Flush dominates a same-cycle reservation.
  - rsv_valid_i && rsv_addr_i == a -> 1. A new reservation wins over a same-cycle write-back to a, because the younger producer is still outstanding.
  - any we_i[p] with waddr_i[p] == a -> 0.
  - otherwise hold.
- rbusy_o[r] = pending[raddr_i[r]] from the register state; there is no bypass on the busy bit. busy_vec_o = pending, with bit 0 always 0.
- Writing a non-pending register is legal; data updates and pending stays 0.
- Reserving an already pending register is legal; it stays 1.
- There is no count of outstanding producers per register. In-order issue guarantees a single outstanding writer per register.
- Throughput: one write per port per cycle and one reservation per cycle, with no back-pressure.

Decomposition:
- Add to segre_pkg:
  - rf_rport_t / rf_wport_t structs {addr, data, we}.
  - Localparams for the default port counts.
  - Keep the existing rf_wdata_t. A thin adapter in the core maps its ex/mem/rvm fields onto ports 0/1/2, which preserves the EX > MEM > RVM priority.
- One sub-module, segre_rf_wsel: a combinational per-register priority write-select producing {hit, data}. It is shared by the storage write path and the read bypass so that both use identical priority.
- The scoreboard stays inline.

Test Plan:
- Reset: assert rsn_i low mid-cycle after writing x5=0xDEADBEEF -> rdata for x5 = 0 immediately, busy_vec_o = 0.
- Priority: we=3'b111, all ports to x7 with data 0x11/0x22/0x33 -> next cycle x7 reads 0x11. With BYPASS=1, the same-cycle read of x7 also returns 0x11.
- x0: write 0xFFFFFFFF to x0 and reserve x0 -> reads 0, busy_vec_o[0] = 0.
- Scoreboard: reserve x9 -> next cycle rbusy = 1. Write-back to x9 on port 2 -> cleared the following cycle, data visible.
- Collision: reserve x4 and write x4 in the same cycle -> pending[4] = 1 afterwards and data updated. Then flush_i together with a reservation of x6 -> busy_vec_o = 0.
- BYPASS=0 build: write x3=0xA5 and read x3 in the same cycle -> old value that cycle, 0xA5 the next cycle.
